// File: rtl/score_keeper_if.sv
// Game-event inputs and score/status outputs of the score keeper.
interface score_keeper_if;
    logic        game_start;
    logic        brick_hit;
    logic [3:0]  brick_points;
    logic        paddle_hit;
    logic        ball_lost;
    logic [13:0] current_score;
    logic [13:0] high_score;
    logic [2:0]  lives;
    logic        playing;
    logic        game_over;
    logic        new_high;

    modport master (
        output game_start, brick_hit, brick_points, paddle_hit, ball_lost,
        input  current_score, high_score, lives, playing, game_over, new_high
    );

    modport slave (
        input  game_start, brick_hit, brick_points, paddle_hit, ball_lost,
        output current_score, high_score, lives, playing, game_over, new_high
    );
endinterface

// File: rtl/score_keeper.sv
// Breakout score keeper: IDLE/PLAY/OVER game FSM with combo scoring,
// saturating score, lives and a high score kept since reset.
module score_keeper #(
    parameter int MAX_SCORE   = 9999,
    parameter int START_LIVES = 3,
    parameter int COMBO_MAX   = 4
) (
    input logic          clk,
    input logic          rst_n,
    score_keeper_if.slave sk
);
    localparam int CW = $clog2(COMBO_MAX + 1);

    typedef enum logic [1:0] {IDLE, PLAY, OVER} state_t;

    state_t        state;
    logic [13:0]   score;
    logic [13:0]   high;
    logic [2:0]    lives;
    logic [CW-1:0] combo;
    logic          raised;
    logic          playing;
    logic          game_over;
    logic          new_high;

    logic [16:0] gain;
    logic [16:0] sum;
    logic [13:0] sat;
    logic        raise_now;

    // Widened sum so a large combo product can never wrap before saturation.
    always_comb begin
        gain      = 17'(sk.brick_points) * 17'(combo);
        sum       = {3'b000, score} + gain;
        sat       = (sum > 17'(MAX_SCORE)) ? 14'(MAX_SCORE) : sum[13:0];
        raise_now = sk.brick_hit && (sat > high);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            score     <= '0;
            high      <= '0;
            lives     <= '0;
            combo     <= CW'(1);
            raised    <= 1'b0;
            playing   <= 1'b0;
            game_over <= 1'b0;
            new_high  <= 1'b0;
        end else begin
            case (state)
                IDLE, OVER: begin
                    if (sk.game_start) begin
                        state     <= PLAY;
                        score     <= '0;
                        lives     <= 3'(START_LIVES);
                        combo     <= CW'(1);
                        raised    <= 1'b0;
                        playing   <= 1'b1;
                        game_over <= 1'b0;
                        new_high  <= 1'b0;
                    end
                end
                PLAY: begin
                    if (sk.brick_hit) begin
                        score <= sat;
                        if (raise_now) high <= sat;
                    end
                    // A same-cycle hit has already been priced with the old combo.
                    if (sk.paddle_hit || sk.ball_lost)
                        combo <= CW'(1);
                    else if (sk.brick_hit && (combo < CW'(COMBO_MAX)))
                        combo <= combo + CW'(1);
                    if (raise_now) raised <= 1'b1;
                    if (sk.ball_lost && (lives != 3'd0)) begin
                        lives <= lives - 3'd1;
                        if (lives == 3'd1) begin
                            state     <= OVER;
                            playing   <= 1'b0;
                            game_over <= 1'b1;
                            new_high  <= raised | raise_now;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign sk.current_score = score;
    assign sk.high_score    = high;
    assign sk.lives         = lives;
    assign sk.playing       = playing;
    assign sk.game_over     = game_over;
    assign sk.new_high      = new_high;
endmodule
